// File: rtl/grand_encoder.sv
`default_nettype none
// ============================================================================
// Module      : grand_encoder
// Description : Serial GF(2) linear block encoder; c = XOR of generator rows
//               selected by msg, accumulated one row per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module grand_encoder #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:K-1]         msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:N-1]         c,
    input  logic                 g_we,
    input  logic [$clog2(K)-1:0] g_row,
    input  logic [0:N-1]         g_data,
    output logic                 g_err,
    output logic [15:0]          enc_count
);

    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [0:K-1]       r_msg;
    logic [0:N-1]       r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [0:N-1]       r_g [K];
    logic               r_g_err;
    logic [15:0]        r_enc_count;
    logic               w_accept;
    logic               w_handoff;
    logic               w_last;
    logic               w_row_ok;
    logic               w_g_write;

    // Extended-Hamming rows for the 8/4 geometry, identity rows otherwise.
    function automatic logic [0:N-1] default_row(input int row);
        logic [0:N-1] v;
        logic [0:7]   h;
        v = '0;
        h = '0;
        if (N == 8 && K == 4) begin
            case (row)
                0:       h = 8'b1000_0111;
                1:       h = 8'b0100_1011;
                2:       h = 8'b0010_1101;
                default: h = 8'b0001_1110;
            endcase
            v = N'(h);
        end else begin
            for (int j = 0; j < N; j++) begin
                v[j] = (j == row);
            end
        end
        return v;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_handoff = (r_state == S_DONE) && out_ready;
    assign w_last    = (32'(r_idx) == K - 1);
    assign w_row_ok  = (32'(g_row) < K);
    assign w_g_write = g_we && (r_state == S_IDLE) && w_row_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        c           = '0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                c         = r_acc;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A row written in the accepting cycle is already visible to the first
    // ACCUM step, since accumulation starts one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msg       <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_g_err     <= 1'b0;
            r_enc_count <= 16'd0;
            for (int i = 0; i < K; i++) begin
                r_g[i] <= default_row(i);
            end
        end else begin
            r_g_err <= g_we && !w_g_write;
            if (w_g_write) begin
                r_g[g_row] <= g_data;
            end
            if (w_accept) begin
                r_msg <= msg;
                r_acc <= '0;
                r_idx <= '0;
            end else if (r_state == S_ACCUM) begin
                if (r_msg[r_idx]) begin
                    r_acc <= r_acc ^ r_g[r_idx];
                end
                r_idx <= r_idx + 1'b1;
            end
            if (w_handoff) begin
                r_enc_count <= r_enc_count + 16'd1;
            end
        end
    end

    assign g_err     = r_g_err;
    assign enc_count = r_enc_count;

endmodule
`default_nettype wire

// File: doc/grand_encoder.md
GRAND_ENCODER -- requirements
Module: grand_encoder

Interface
REQ-001 Parameter N, default 8: codeword length in bits.
REQ-002 Parameter K, default 4: message length in bits, with 1 <= K <= N.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  message present on msg.
REQ-006 in_ready  output  1  encoder can accept a message.
REQ-007 msg  input  [0:K-1]  message; msg[i] selects generator row i.
REQ-008 out_valid  output  1  codeword present on c.
REQ-009 out_ready  input  1  consumer accepts c.
REQ-010 c  output  [0:N-1]  encoded codeword, MSB-first index 0.
REQ-011 g_we  input  1  generator-row write strobe.
REQ-012 g_row  input  [$clog2(K)-1:0]  row index to write.
REQ-013 g_data  input  [0:N-1]  row value to write.
REQ-014 g_err  output  1  one-cycle pulse when a write is rejected.
REQ-015 enc_count  output  16  number of completed codeword handoffs.

Function
REQ-016 The block SHALL hold a K x N generator matrix G in registers; c = XOR of G[i] over every i with msg[i]=1, in GF(2).
REQ-017 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready, latch msg, clear acc to 0 and idx to 0, then go to ACCUM.
REQ-019 ACCUM: each cycle, acc ^= G[idx] if msg_reg[idx]=1, then idx++; after processing idx=K-1, go to DONE.
REQ-020 DONE: out_valid=1 and c=acc; on out_ready, increment enc_count (16-bit wrap 0xFFFF->0) and go to IDLE.
REQ-021 in_ready SHALL be 0 in ACCUM and DONE.
REQ-022 in_valid outside IDLE SHALL be ignored.
REQ-023 Latency: out_valid SHALL rise exactly K cycles after the accepting edge.
REQ-024 c SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 A new message SHALL be accepted no earlier than the cycle after the DONE handoff; throughput is one codeword per K+2 cycles.
REQ-026 c SHALL be 0 whenever out_valid=0.
REQ-027 A g_we in IDLE SHALL write G[g_row]=g_data at that edge.
REQ-028 A g_we with g_row >= K SHALL be dropped and SHALL raise g_err.
REQ-029 A g_we in ACCUM or DONE SHALL be dropped and SHALL raise g_err for one cycle.
REQ-030 g_we and in_valid in the same IDLE cycle: both SHALL take effect, and the new row SHALL be used for this message.
REQ-031 msg=0 SHALL still take the full K-cycle path and yield c=0.

Reset
REQ-032 On rst, asynchronously: state=IDLE, in_ready=1, out_valid=0, c=0, g_err=0, enc_count=0, acc=0, idx=0.
REQ-033 On rst, G SHALL load the default extended-Hamming rows (N=8, K=4): G0=1000_0111, G1=0100_1011, G2=0010_1101, G3=0001_1110.
REQ-034 rst mid-operation SHALL abort the message with no output and no count increment; any previously written G is overwritten by the defaults.

Verification
REQ-035 Default G, msg=0000 -> out_valid after 4 cycles, c=0000_0000, enc_count=1.
REQ-036 Default G, msg=1000 -> c=1000_0111; msg=1011 -> c=1011_0100.
REQ-037 msg=1011 with out_ready held 0 for 5 cycles -> c stays 1011_0100, in_ready=0, and a second in_valid is ignored.
REQ-038 In IDLE write G[1]=1111_1111, then msg=0100 -> c=1111_1111; a g_we in ACCUM -> g_err pulse, G unchanged.
REQ-039 Assert rst during ACCUM of msg=1000 -> out_valid=0, enc_count=0; the next msg=1000 -> c=1000_0111.
REQ-040 With enc_count preloaded to 0xFFFF by 65535 handoffs, one more handoff -> enc_count=0x0000.
